// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM refresh logic.
//   T_REFI_CLKS  : clocks per auto-refresh interval (7.8 us at 50 MHz)
//   MAX_POSTPONE : owed-refresh saturation limit (JEDEC postpone limit)
//   URGENT_LEVEL : owed-refresh count at which the arbiter should pre-empt
//   state_t      : refresh scheduler FSM encoding
package sdram_pkg;

   localparam int T_REFI_CLKS  = 390;
   localparam int MAX_POSTPONE = 8;
   localparam int URGENT_LEVEL = 6;

   typedef enum logic [1:0] {
      WAIT_INIT = 2'd0,
      RUN       = 2'd1,
      PAUSED    = 2'd2
   } state_t;

endpackage

// File: rtl/sdram_interval_timer.sv
// Reloadable down-counter marking refresh intervals.
//   clk, reset : clock, async active-high reset
//   run        : counting allowed in this cycle
//   hold       : freeze the counter (takes priority over run)
//   restart    : reload INTERVAL-1 on the next edge (highest priority)
//   tick       : one-cycle pulse while counting and the counter is 0
module sdram_interval_timer #(
   parameter int INTERVAL = 390,
   parameter int CNT_W    = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic hold,
   input  logic restart,
   output logic tick
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(INTERVAL - 1);

   logic [CNT_W-1:0] count;
   logic             active;

   assign active = run && !hold && !restart;
   assign tick   = active && (count == '0);

   // Reloading on the tick edge makes the tick period exactly INTERVAL clocks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= RELOAD;
      end else if (restart) begin
         count <= RELOAD;
      end else if (active) begin
         count <= (count == '0) ? RELOAD : count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// Auto-refresh scheduler: interval timing, owed-refresh accounting and the
// req/ack handshake towards the SDRAM command sequencer.
//   clk, reset   : clock, async active-high reset
//   init_done    : SDRAM power-up sequence complete (level)
//   enable       : refresh scheduling enabled (level; low in self-refresh)
//   ref_ack      : one-cycle pulse, one AUTO REFRESH issued
//   clr_overflow : synchronous clear of the overflow flag
//   ref_req      : at least one refresh owed
//   ref_urgent   : owed count >= URGENT_AT
//   pending      : owed-refresh count
//   tick         : one-cycle pulse at each interval expiry
//   overflow     : sticky, an interval expired while already saturated
//
// state     | meaning
// WAIT_INIT | SDRAM not initialised; counter held at INTERVAL-1
// RUN       | counting intervals while enable is high
// PAUSED    | enable low; counter frozen, handshake still active
module sdram_refresh_scheduler
   import sdram_pkg::*;
#(
   parameter int INTERVAL    = T_REFI_CLKS,
   parameter int CNT_W       = 16,
   parameter int MAX_PENDING = MAX_POSTPONE,
   parameter int URGENT_AT   = URGENT_LEVEL,
   parameter int PEND_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init_done,
   input  logic              enable,
   input  logic              ref_ack,
   input  logic              clr_overflow,
   output logic              ref_req,
   output logic              ref_urgent,
   output logic [PEND_W-1:0] pending,
   output logic              tick,
   output logic              overflow
);

   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
   localparam logic [PEND_W-1:0] PEND_URG = PEND_W'(URGENT_AT);

   state_t            state, state_nxt;
   logic [PEND_W-1:0] pend_nxt;
   logic              ovf_set;
   logic              restart;

   // Losing init_done reloads the timer in the same cycle it is seen.
   assign restart = (state == WAIT_INIT) || !init_done;

   sdram_interval_timer #(
      .INTERVAL (INTERVAL),
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .run     (state == RUN),
      .hold    (!enable),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      state_nxt = state;
      if (!init_done) begin
         state_nxt = WAIT_INIT;
      end else begin
         case (state)
            WAIT_INIT: state_nxt = RUN;
            RUN:       if (!enable) state_nxt = PAUSED;
            PAUSED:    if (enable)  state_nxt = RUN;
            default:   state_nxt = WAIT_INIT;
         endcase
      end
   end

   // A tick and an ack in the same cycle cancel, so saturation is not
   // flagged when a refresh is being consumed as a new one comes due.
   always_comb begin
      pend_nxt = pending;
      ovf_set  = 1'b0;
      if (!init_done) begin
         pend_nxt = '0;
      end else if (tick && !ref_ack) begin
         if (pending == PEND_MAX) begin
            ovf_set = 1'b1;
         end else begin
            pend_nxt = pending + PEND_W'(1);
         end
      end else if (ref_ack && !tick) begin
         if (pending != '0) begin
            pend_nxt = pending - PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= WAIT_INIT;
         pending    <= '0;
         ref_req    <= 1'b0;
         ref_urgent <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         pending    <= pend_nxt;
         ref_req    <= (pend_nxt != '0);
         ref_urgent <= (pend_nxt >= PEND_URG);
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
module tb_sdram_refresh_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       init_done = 1'b0;
   logic       enable = 1'b0;
   logic       ref_ack = 1'b0;
   logic       clr_overflow = 1'b0;
   logic       ref_req, ref_urgent, tick, overflow;
   logic [2:0] pending;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sdram_refresh_scheduler #(
      .INTERVAL    (10),
      .CNT_W       (16),
      .MAX_PENDING (4),
      .URGENT_AT   (3),
      .PEND_W      (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .init_done    (init_done),
      .enable       (enable),
      .ref_ack      (ref_ack),
      .clr_overflow (clr_overflow),
      .ref_req      (ref_req),
      .ref_urgent   (ref_urgent),
      .pending      (pending),
      .tick         (tick),
      .overflow     (overflow)
   );

   typedef struct {
      int   cyc;
      logic init, en, ack, clr;
      int   p;
      logic req, urg, tk, ovf;
   } vec_t;

   vec_t vecs[17];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input int p, input int req,
                            input int urg, input int tk, input int ovf);
      check({name, "_pending"}, int'(pending), p);
      check({name, "_req"}, int'(ref_req), req);
      check({name, "_urgent"}, int'(ref_urgent), urg);
      check({name, "_tick"}, int'(tick), tk);
      check({name, "_overflow"}, int'(overflow), ovf);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      init_done = 1'b0;
      enable = 1'b0;
      ref_ack = 1'b0;
      clr_overflow = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic start();
      do_reset();
      init_done = 1'b1;
      enable = 1'b1;
      step();
   endtask

   // Steps until tick is seen; n = number of steps taken.
   task automatic wait_tick(input string name, output int n);
      n = 0;
      while (tick !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      if (tick !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no tick expected tick within 40 cycles", name);
      end
   endtask

   task automatic tick_then_step(input string name);
      int n;
      wait_tick(name, n);
      step();
   endtask

   initial begin
      int n;
      logic saw_tick;

      vecs[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{8, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
      vecs[3]  = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
      vecs[4]  = '{9, 1, 1, 0, 0, 1, 1, 0, 1, 0};
      vecs[5]  = '{1, 1, 1, 0, 0, 2, 1, 0, 0, 0};
      vecs[6]  = '{10, 1, 1, 0, 0, 3, 1, 1, 0, 0};
      vecs[7]  = '{10, 1, 1, 0, 0, 4, 1, 1, 0, 0};
      vecs[8]  = '{9, 1, 1, 0, 0, 4, 1, 1, 1, 0};
      vecs[9]  = '{1, 1, 1, 0, 0, 4, 1, 1, 0, 1};
      vecs[10] = '{1, 1, 1, 1, 0, 3, 1, 1, 0, 1};
      vecs[11] = '{1, 1, 1, 1, 0, 2, 1, 0, 0, 1};
      vecs[12] = '{1, 1, 1, 1, 0, 1, 1, 0, 0, 1};
      vecs[13] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
      vecs[14] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
      vecs[15] = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
      vecs[16] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};

      do_reset();
      check_all("reset", 0, 0, 0, 0, 0);

      // Periodic ticks, saturation, ack drain and overflow clear.
      for (int i = 0; i < 17; i++) begin
         init_done = vecs[i].init;
         enable = vecs[i].en;
         ref_ack = vecs[i].ack;
         clr_overflow = vecs[i].clr;
         repeat (vecs[i].cyc) step();
         check_all($sformatf("vec%0d", i), vecs[i].p, int'(vecs[i].req),
                   int'(vecs[i].urg), int'(vecs[i].tk), int'(vecs[i].ovf));
      end
      ref_ack = 1'b0;
      clr_overflow = 1'b0;

      // Ack two cycles after ref_req rises, then a stray ack at zero.
      start();
      tick_then_step("hs");
      check("hs_req_rise", int'(ref_req), 1);
      step();
      ref_ack = 1'b1;
      step();
      check("hs_ack_pend", int'(pending), 0);
      check("hs_ack_req", int'(ref_req), 0);
      step();
      ref_ack = 1'b0;
      check("hs_zero_ack_pend", int'(pending), 0);
      check("hs_zero_ack_ovf", int'(overflow), 0);

      // Ack coinciding with tick.
      tick_then_step("co1");
      tick_then_step("co2");
      check("co_pend2", int'(pending), 2);
      wait_tick("co3", n);
      ref_ack = 1'b1;
      step();
      ref_ack = 1'b0;
      check("co_ack_tick_p2", int'(pending), 2);
      tick_then_step("co4");
      tick_then_step("co5");
      check("co_pend4", int'(pending), 4);
      wait_tick("co6", n);
      ref_ack = 1'b1;
      step();
      ref_ack = 1'b0;
      check("co_ack_tick_p4", int'(pending), 4);
      check("co_ack_tick_ovf", int'(overflow), 0);

      // Pause mid-interval.
      start();
      tick_then_step("pa");
      check("pa_pend1", int'(pending), 1);
      repeat (4) step();
      enable = 1'b0;
      saw_tick = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tick) saw_tick = 1'b1;
      end
      ref_ack = 1'b1;
      step();
      ref_ack = 1'b0;
      check("pa_ack_pend", int'(pending), 0);
      check("pa_ack_req", int'(ref_req), 0);
      for (int i = 0; i < 9; i++) begin
         step();
         if (tick) saw_tick = 1'b1;
      end
      check("pa_no_tick", int'(saw_tick), 0);
      enable = 1'b1;
      wait_tick("pa_resume", n);
      check("pa_resume_cycles", n, 6);
      step();
      check("pa_resume_pend", int'(pending), 1);

      // Async reset mid-interval with pending=3 and overflow set.
      start();
      repeat (5) tick_then_step("rs");
      check("rs_sat_ovf", int'(overflow), 1);
      ref_ack = 1'b1;
      step();
      ref_ack = 1'b0;
      check("rs_pend3", int'(pending), 3);
      repeat (3) step();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_all("rs_async", 0, 0, 0, 0, 0);
      step();
      reset = 1'b0;
      wait_tick("rs_first", n);
      check("rs_first_tick_cycles", n, 10);

      // init_done drop keeps overflow; clear vs saturation priority.
      start();
      repeat (5) tick_then_step("id");
      ref_ack = 1'b1;
      step();
      step();
      ref_ack = 1'b0;
      check("id_pend2", int'(pending), 2);
      init_done = 1'b0;
      step();
      check_all("id_drop", 0, 0, 0, 0, 1);
      init_done = 1'b1;
      wait_tick("id_reload", n);
      check("id_reload_cycles", n, 10);
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      check("id_clr_ovf", int'(overflow), 0);
      check("id_pend1", int'(pending), 1);
      repeat (3) tick_then_step("id_fill");
      check("id_pend4", int'(pending), 4);
      wait_tick("id_sat", n);
      clr_overflow = 1'b1;
      step();
      check("id_set_wins", int'(overflow), 1);
      step();
      clr_overflow = 1'b0;
      check("id_clr_after", int'(overflow), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sdram_refresh_scheduler.md
Name: sdram_refresh_scheduler

Overview:
- Generates periodic auto-refresh requests for the SDRAM controller; it produces the interval/count values that the controller's magnitude comparisons act on.
- A reloadable down-counter marks each refresh interval. A saturating pending-refresh counter accumulates owed refreshes.
- A req/ack handshake hands refreshes to the command sequencer. An urgency flag lets the arbiter pre-empt normal accesses.

Parameters:
- INTERVAL, 390, clocks per refresh interval (7.8 us at 50 MHz); legal range 2..2^CNT_W-1
- CNT_W, 16, width of the interval counter
- MAX_PENDING, 8, saturation limit of owed refreshes (JEDEC postpone limit)
- URGENT_AT, 6, pending count at or above which ref_urgent asserts; must be <= MAX_PENDING
- PEND_W, 4, width of pending counter; must hold MAX_PENDING

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high reset
- init_done  in  1  SDRAM power-up/mode-register sequence is complete; level signal
- enable  in  1  refresh scheduling enabled; level signal, e.g. low during self-refresh
- ref_ack  in  1  one-cycle pulse: sequencer has issued one AUTO REFRESH
- ref_req  out  1  at least one refresh is owed
- ref_urgent  out  1  pending >= URGENT_AT
- pending  out  PEND_W  current owed-refresh count
- tick  out  1  one-cycle pulse at each interval expiry (debug/perf)
- overflow  out  1  sticky flag: an interval expired while pending == MAX_PENDING
- clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release):
  - counter = INTERVAL-1, pending = 0, state = WAIT_INIT
  - ref_req, ref_urgent, tick, overflow all 0
- FSM states:
  - WAIT_INIT: counter held at INTERVAL-1; no ticks. Moves to RUN on the first cycle init_done = 1.
  - RUN: if enable = 1, counter decrements once per cycle. If enable = 0, counter holds its value (no reload) and the FSM moves to PAUSED.
  - PAUSED: counter frozen; pending and handshake still operate. Returns to RUN when enable = 1; counting resumes from the frozen value.
  - init_done falling in any state: return to WAIT_INIT, reload counter, clear pending. overflow is kept.
- Tick: in RUN with enable = 1 and counter == 0:
  - tick = 1 for that cycle
  - counter reloads INTERVAL-1 on the next edge, so the tick period is exactly INTERVAL clocks
- Pending update, evaluated every cycle:
  - tick only: pending+1; if pending == MAX_PENDING, hold at MAX_PENDING and set overflow
  - ack only: pending-1 if pending > 0; ack at pending == 0 is ignored (no underflow, no flag)
  - tick and ack together: pending unchanged; overflow is not set even at MAX_PENDING
- Outputs are registered and derived from next-state pending:
  - ref_req = (pending != 0)
  - ref_urgent = (pending >= URGENT_AT)
  - Latency from the tick edge to ref_req rising: 0 cycles (same edge as pending update)
  - ref_req falls on the edge that consumes the last ack
- Handshake:
  - The sequencer may pulse ref_ack only while ref_req = 1. One ack consumes one refresh.
  - Back-to-back acks on consecutive cycles are legal and each decrements pending.
  - ref_req stays high while pending > 0. There is no per-request deassertion between refreshes.
- overflow:
  - set by the saturation condition above
  - cleared by clr_overflow on the next edge
  - if set and clear coincide, set wins
  - only reset also clears it
- Counter width: compare counter to 0 only. No other magnitude compares are needed in this block.

Decomposition:
- Shared package sdram_pkg holds:
  - refresh timing constants: T_REFI_CLKS, MAX_POSTPONE, URGENT_LEVEL
  - FSM state encoding typedef: WAIT_INIT = 2'd0, RUN = 2'd1, PAUSED = 2'd2
- One sub-module, sdram_interval_timer:
  - parameterised by INTERVAL and CNT_W
  - inputs: run, hold, restart
  - output: tick
  - contains the reloadable down-counter
- The top level holds the FSM, the pending counter, the flags and the handshake.

Test Plan (INTERVAL=10, MAX_PENDING=4, URGENT_AT=3, PEND_W=3):
1. Reset, init_done=1, enable=1, no acks -> tick pulses every 10 clocks; pending 1,2,3,4; ref_urgent high at pending = 3; the 5th tick holds pending at 4 and sets overflow.
2. init_done=1, pending=1, ack 2 cycles after ref_req rises -> pending 0, ref_req low on that edge. A second ack at pending 0 -> no change, no overflow.
3. Drive ref_ack on the exact cycle tick=1 with pending = 2 -> pending stays 2. Repeat at pending = 4 -> stays 4, overflow remains 0.
4. Drop enable after 4 counting cycles for 20 clocks, then raise it -> the next tick arrives 6 clocks after re-enable; an ack during pause still decrements pending.
5. With pending = 3 and overflow = 1, pulse reset mid-interval asynchronously -> all outputs 0 immediately; after release plus init_done, the first tick occurs 10 clocks later.
6. Drop init_done with pending = 2 -> pending 0 and counter reloaded; overflow is kept until clr_overflow; clr_overflow coinciding with a saturation tick -> overflow stays 1.
